// File: rtl/im_load_ctrl_if.sv
// Loader stream, core fetch and instruction-memory port bundle for im_load_ctrl.
// Latency: none, wires only.
// Backpressure: load_ready from the controller qualifies load_valid beats.
interface im_load_ctrl_if #(
    parameter int DATA_W = 32
);
    // loader word stream
    logic              start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    // core side
    logic [31:0]       fetch_pc;
    logic              core_stall;
    // instruction-memory port
    logic [31:0]       im_addr;
    logic [DATA_W-1:0] im_data;
    logic              im_write;
    logic              im_read;

    modport master (
        input  start, load_valid, load_data, load_last, fetch_pc,
        output load_ready, core_stall, im_addr, im_data, im_write, im_read
    );

    modport slave (
        output start, load_valid, load_data, load_last, fetch_pc,
        input  load_ready, core_stall, im_addr, im_data, im_write, im_read
    );
endinterface

// File: rtl/im_load_ctrl.sv
// Shares the IM port between core fetch and a run-time program loader.
// Latency: write lands in the accept cycle (IM captures on negedge); done 2 cycles after the last beat.
// Backpressure: load_ready only in LOAD; core stalled from LOAD entry through DRAIN.
module im_load_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    im_load_ctrl_if.master    bus,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt,
    output logic              trunc_err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              load_ready_q;
    logic              core_stall_q;
    logic              im_read_q;
    logic              accept;

    assign accept = (state == LOAD) && bus.load_valid && load_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            word_cnt     <= '0;
            trunc_err    <= 1'b0;
            done         <= 1'b0;
            load_ready_q <= 1'b0;
            core_stall_q <= 1'b0;
            im_read_q    <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= LOAD;
                        wr_ptr       <= '0;
                        word_cnt     <= '0;
                        trunc_err    <= 1'b0;
                        load_ready_q <= 1'b1;
                        core_stall_q <= 1'b1;
                        im_read_q    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        word_cnt <= word_cnt + (ADDR_W+1)'(1);
                        // Pointer never wraps inside a session; the next start rezeroes it.
                        if (wr_ptr != LAST_PTR)
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                        if (bus.load_last || wr_ptr == LAST_PTR) begin
                            state        <= DRAIN;
                            load_ready_q <= 1'b0;
                            im_read_q    <= 1'b1;
                            trunc_err    <= !bus.load_last;
                        end
                    end
                end
                DRAIN: begin
                    // One settle cycle for the IM read mux before the core resumes.
                    state        <= IDLE;
                    done         <= 1'b1;
                    core_stall_q <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    load_ready_q <= 1'b0;
                    core_stall_q <= 1'b0;
                    im_read_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.core_stall = core_stall_q;
    assign bus.im_read    = im_read_q;
    assign bus.im_write   = accept;
    assign bus.im_addr    = (state == LOAD) ? {{(30-ADDR_W){1'b0}}, wr_ptr, 2'b00} : bus.fetch_pc;
    assign bus.im_data    = (state == LOAD) ? bus.load_data : '0;
endmodule

// File: tb/tb_im_load_ctrl.sv
// Directed bench for im_load_ctrl with a negedge-capturing IM model.
// Inputs change 1ns after posedge; outputs are checked 2ns after posedge.
module tb_im_load_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        done;
    logic [4:0]  word_cnt;
    logic        trunc_err;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] imem [16];
    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];
    int          done_cnt;

    im_load_ctrl_if #(.DATA_W(32)) bus ();

    im_load_ctrl #(.DEPTH(16), .ADDR_W(4), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .done      (done),
        .word_cnt  (word_cnt),
        .trunc_err (trunc_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.im_write) begin
            imem[bus.im_addr[5:2]] = bus.im_data;
            wq_addr.push_back(bus.im_addr);
            wq_data.push_back(bus.im_data);
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    endtask

    task automatic clear_log();
        wq_addr.delete(); wq_data.delete(); done_cnt = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.fetch_pc = 32'h14;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); #1;
        n_checks++; if (bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", bus.core_stall); end
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", bus.load_ready); end
        n_checks++; if (bus.im_write !== 1'b0) begin n_fail++; $display("FAIL rst_write got %b want 0", bus.im_write); end
        n_checks++; if (bus.im_read !== 1'b1) begin n_fail++; $display("FAIL rst_read got %b want 1", bus.im_read); end
        n_checks++; if (bus.im_addr !== 32'h14) begin n_fail++; $display("FAIL rst_addr got %h want 00000014", bus.im_addr); end
        n_checks++; if (bus.im_data !== 32'h0) begin n_fail++; $display("FAIL rst_data got %h want 0", bus.im_data); end
        n_checks++; if (word_cnt !== 5'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", word_cnt); end
        n_checks++; if (trunc_err !== 1'b0) begin n_fail++; $display("FAIL rst_trunc got %b want 0", trunc_err); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        bus.fetch_pc = 32'h20; #1;
        n_checks++; if (bus.im_addr !== 32'h20) begin n_fail++; $display("FAIL rst_addr_track got %h want 00000020", bus.im_addr); end
    endtask

    task automatic test_three_words();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA1; exp_d[1] = 32'hA2; exp_d[2] = 32'hA3;
        clear_log();
        tick(); bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.start = 1'b0; bus.load_valid = 1'b1; bus.load_data = exp_d[i]; bus.load_last = (i == 2);
            #1;
            n_checks++; if (bus.im_write !== 1'b1 || bus.im_addr !== 32'(i*4)) begin n_fail++; $display("FAIL bb_write%0d got we=%b addr=%h want we=1 addr=%h", i, bus.im_write, bus.im_addr, 32'(i*4)); end
            n_checks++; if (bus.core_stall !== 1'b1) begin n_fail++; $display("FAIL bb_stall%0d got %b want 1", i, bus.core_stall); end
        end
        tick(); idle_inputs(); #1;
        n_checks++; if ({bus.core_stall, bus.load_ready, bus.im_write, bus.im_read, done} !== 5'b10010) begin n_fail++; $display("FAIL bb_drain got %b want 10010", {bus.core_stall, bus.load_ready, bus.im_write, bus.im_read, done}); end
        tick(); #1;
        n_checks++; if (done !== 1'b1 || bus.core_stall !== 1'b0) begin n_fail++; $display("FAIL bb_done got done=%b stall=%b want 1 0", done, bus.core_stall); end
        n_checks++; if (word_cnt !== 5'd3 || trunc_err !== 1'b0) begin n_fail++; $display("FAIL bb_cnt got cnt=%0d trunc=%b want 3 0", word_cnt, trunc_err); end
        tick(); #1;
        n_checks++; if (done !== 1'b0 || done_cnt != 1) begin n_fail++; $display("FAIL bb_done_once got done=%b pulses=%0d want 0 1", done, done_cnt); end
        n_checks++; if (wq_addr.size() != 3) begin n_fail++; $display("FAIL bb_nwrites got %0d want 3", wq_addr.size()); end
        for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
            n_checks++; if (wq_addr[i] !== 32'(i*4) || wq_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL bb_log%0d got %h/%h want %h/%h", i, wq_addr[i], wq_data[i], 32'(i*4), exp_d[i]); end
        end
        bus.fetch_pc = 32'h8; #1;
        n_checks++; if (bus.im_read !== 1'b1 || imem[bus.im_addr[5:2]] !== 32'hA3) begin n_fail++; $display("FAIL bb_fetch got rd=%b word=%h want 1 000000a3", bus.im_read, imem[bus.im_addr[5:2]]); end
    endtask

    task automatic test_gaps();
        logic [3:0] vpat;
        vpat = 4'b1001;
        clear_log();
        tick(); bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.start = 1'b0; bus.load_valid = vpat[i]; bus.load_data = 32'hB0 + 32'(i); bus.load_last = (i == 3);
            #1;
            n_checks++; if (bus.core_stall !== 1'b1 || bus.im_write !== vpat[i]) begin n_fail++; $display("FAIL gap_cyc%0d got stall=%b we=%b want 1 %b", i, bus.core_stall, bus.im_write, vpat[i]); end
        end
        tick(); idle_inputs(); #1;
        n_checks++; if (bus.core_stall !== 1'b1 || bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL gap_drain got stall=%b rdy=%b want 1 0", bus.core_stall, bus.load_ready); end
        tick(); #1;
        n_checks++; if (done !== 1'b1 || word_cnt !== 5'd2) begin n_fail++; $display("FAIL gap_done got done=%b cnt=%0d want 1 2", done, word_cnt); end
        n_checks++; if (wq_addr.size() != 2) begin n_fail++; $display("FAIL gap_nwrites got %0d want 2", wq_addr.size()); end
        else begin
            n_checks++; if (wq_addr[0] !== 32'h0 || wq_addr[1] !== 32'h4 || wq_data[1] !== 32'hB3) begin n_fail++; $display("FAIL gap_log got %h %h %h want 0 4 b3", wq_addr[0], wq_addr[1], wq_data[1]); end
        end
    endtask

    task automatic test_trunc();
        int bad;
        clear_log();
        bad = 0;
        tick(); bus.start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.start = 1'b0; bus.load_valid = 1'b1; bus.load_data = 32'h100 + 32'(i); bus.load_last = 1'b0;
            #1;
            if (bus.im_write !== 1'b1 || bus.im_addr !== 32'(i*4)) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL tr_addr_seq got %0d bad beats want 0", bad); end
        tick(); #1;
        n_checks++; if (bus.im_write !== 1'b0 || bus.load_ready !== 1'b0 || bus.core_stall !== 1'b1) begin n_fail++; $display("FAIL tr_drain got we=%b rdy=%b stall=%b want 0 0 1", bus.im_write, bus.load_ready, bus.core_stall); end
        idle_inputs();
        tick(); #1;
        n_checks++; if (done !== 1'b1 || word_cnt !== 5'd16 || trunc_err !== 1'b1) begin n_fail++; $display("FAIL tr_done got done=%b cnt=%0d trunc=%b want 1 16 1", done, word_cnt, trunc_err); end
        n_checks++; if (wq_addr.size() != 16 || wq_addr[wq_addr.size()-1] !== 32'h3C) begin n_fail++; $display("FAIL tr_nwrites got %0d writes want 16 ending at 3c", wq_addr.size()); end
        tick(); #1;
        n_checks++; if (trunc_err !== 1'b1 || word_cnt !== 5'd16) begin n_fail++; $display("FAIL tr_sticky got trunc=%b cnt=%0d want 1 16", trunc_err, word_cnt); end
        bus.start = 1'b1;
        tick(); bus.start = 1'b0; #1;
        n_checks++; if (trunc_err !== 1'b0 || word_cnt !== 5'd0) begin n_fail++; $display("FAIL tr_clear got trunc=%b cnt=%0d want 0 0", trunc_err, word_cnt); end
        bus.load_valid = 1'b1; bus.load_data = 32'h55; bus.load_last = 1'b1;
        tick(); idle_inputs();
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        clear_log();
        tick(); bus.start = 1'b1;
        tick(); bus.start = 1'b0; bus.load_valid = 1'b1; bus.load_data = 32'hC1;
        tick(); bus.load_data = 32'hC2;
        tick(); bus.load_valid = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0; #1;
        n_checks++; if (bus.core_stall !== 1'b0 || bus.load_ready !== 1'b0 || word_cnt !== 5'd0) begin n_fail++; $display("FAIL rm_abort got stall=%b rdy=%b cnt=%0d want 0 0 0", bus.core_stall, bus.load_ready, word_cnt); end
        tick(); tick();
        n_checks++; if (done_cnt != 0 || wq_addr.size() != 2) begin n_fail++; $display("FAIL rm_nodone got pulses=%0d writes=%0d want 0 2", done_cnt, wq_addr.size()); end
        bus.start = 1'b1;
        tick(); bus.start = 1'b0; bus.load_valid = 1'b1; bus.load_data = 32'hD1; bus.load_last = 1'b1; #1;
        n_checks++; if (bus.im_write !== 1'b1 || bus.im_addr !== 32'h0) begin n_fail++; $display("FAIL rm_restart got we=%b addr=%h want 1 0", bus.im_write, bus.im_addr); end
        tick(); idle_inputs();
        tick(); #1;
        n_checks++; if (done !== 1'b1 || word_cnt !== 5'd1) begin n_fail++; $display("FAIL rm_done got done=%b cnt=%0d want 1 1", done, word_cnt); end
    endtask

    task automatic test_start_held();
        clear_log();
        tick();
        bus.start = 1'b1; bus.load_valid = 1'b1; bus.load_data = 32'hE0; bus.load_last = 1'b0; #1;
        n_checks++; if (bus.im_write !== 1'b0 || bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL sh_startcyc got we=%b rdy=%b want 0 0", bus.im_write, bus.load_ready); end
        tick(); bus.load_data = 32'hE1; #1;
        n_checks++; if (bus.im_write !== 1'b1 || bus.im_addr !== 32'h0) begin n_fail++; $display("FAIL sh_first got we=%b addr=%h want 1 0", bus.im_write, bus.im_addr); end
        tick(); bus.load_data = 32'hE2; bus.load_last = 1'b1; #1;
        n_checks++; if (bus.im_write !== 1'b1 || bus.im_addr !== 32'h4) begin n_fail++; $display("FAIL sh_norestart got we=%b addr=%h want 1 4", bus.im_write, bus.im_addr); end
        tick(); idle_inputs();
        tick(); #1;
        n_checks++; if (done !== 1'b1 || word_cnt !== 5'd2) begin n_fail++; $display("FAIL sh_done got done=%b cnt=%0d want 1 2", done, word_cnt); end
        n_checks++; if (wq_data.size() != 2 || wq_data[0] !== 32'hE1 || wq_data[1] !== 32'hE2) begin n_fail++; $display("FAIL sh_log got %0d writes want 2 (e1,e2)", wq_data.size()); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        bus.fetch_pc = 32'h0;
        test_reset();
        test_three_words();
        test_gaps();
        test_trunc();
        test_reset_mid();
        test_start_held();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/im_load_ctrl.md
Name: im_load_ctrl

Overview:
- Sequencing controller for the 16-word instruction memory.
- Owns the memory's single address/data/write port and shares it between two users:
  - the core fetch path, which drives the PC;
  - a word-stream loader that overwrites the program at run time.
- While a load is in progress the core is stalled and the port is steered to the loader. On completion, fetch regains the port and a done pulse is issued.

Parameters:
- DEPTH, 16, number of 32-bit instruction words; must be a power of two.
- ADDR_W, 4, word-address width, equal to log2(DEPTH).
- DATA_W, 32, instruction word width.

Ports:
- clk  input  1  system clock; controller state updates on posedge (IM cells capture on negedge).
- reset  input  1  reset, synchronous, active-high.
- start  input  1  begin a load session; sampled in IDLE only.
- load_valid  input  1  loader word available.
- load_data  input  DATA_W  loader word.
- load_last  input  1  marks the final word of the session; qualified by load_valid.
- load_ready  output  1  controller accepts the word this cycle.
- fetch_pc  input  32  core program counter.
- im_addr  output  32  byte address to IM; bits [ADDR_W+1:2] select the word.
- im_data  output  DATA_W  write data to IM.
- im_write  output  1  IM write enable.
- im_read  output  1  IM read enable.
- core_stall  output  1  holds the core PC and pipeline.
- done  output  1  one-cycle pulse at session end.
- word_cnt  output  ADDR_W+1  words written in the current/last session (0..DEPTH).
- trunc_err  output  1  sticky flag: session hit DEPTH words without load_last.

Behaviour:
- States: IDLE, LOAD, DRAIN.
- Reset (synchronous, posedge): state=IDLE, wr_ptr=0, word_cnt=0, trunc_err=0, done=0.
  - Outputs at reset: load_ready=0, im_write=0, core_stall=0, im_addr=fetch_pc, im_data=0.
  - IM contents are restored separately by the IM's own reset; this block does not rewrite them.
- IDLE:
  - im_addr=fetch_pc, im_read=1, im_write=0, load_ready=0, core_stall=0.
  - start=1 -> LOAD next cycle; wr_ptr and word_cnt cleared, trunc_err cleared.
- LOAD:
  - Outputs: core_stall=1, load_ready=1, im_read=0, im_addr={wr_ptr,2'b00} zero-extended to 32 bits, im_data=load_data.
  - im_write = load_valid & load_ready, combinational, so the IM negedge capture lands in the same cycle.
  - Accepted beat (load_valid & load_ready at posedge): wr_ptr++, word_cnt++.
  - If load_last=1 on the accepted beat -> DRAIN.
  - Else if wr_ptr==DEPTH-1 on the accepted beat -> DRAIN, and trunc_err is set.
  - load_valid=0: stall holds, no write, pointer unchanged; no timeout.
  - start during LOAD is ignored.
- DRAIN (one cycle):
  - core_stall=1, load_ready=0, im_write=0, im_addr=fetch_pc, im_read=1. This lets the IM read mux settle on the new contents.
  - Next state IDLE; done=1 for exactly the first IDLE cycle (registered).
- Wrap: wr_ptr is ADDR_W bits and wraps to 0 only at the start of the next session, never within a session.
- Simultaneous start & load_valid in IDLE: the word is not accepted (load_ready=0); acceptance begins the cycle after.
- Reset mid-LOAD:
  - Session aborts with no done pulse; state returns to IDLE and core_stall drops in the cycle after the reset edge.
  - Words already written stay written unless the IM itself is reset.
- word_cnt holds its final value after done until the next start.
- trunc_err remains set until the next start or reset.

Test Plan:
- Reset with start=0 -> core_stall=0, load_ready=0, im_write=0; im_addr tracks fetch_pc=0x14 within the same cycle; word_cnt=0, trunc_err=0.
- start pulse, then 3 back-to-back words 0xA1,0xA2,0xA3 with load_last on the third -> im_write with im_addr 0x0,0x4,0x8, one DRAIN cycle, done high one cycle, word_cnt=3, trunc_err=0; fetch at pc 0x8 returns 0xA3.
- Load with load_valid gaps (valid pattern 1,0,0,1 with last on the second beat) -> exactly 2 writes at addr 0x0,0x4; core_stall held continuously from LOAD entry through DRAIN.
- 16 words with load_last never asserted -> 16 writes, addr 0x0..0x3C, DRAIN after the 16th, word_cnt=16, trunc_err=1; next start clears trunc_err.
- reset asserted after 2 accepted words of a session -> no done pulse, core_stall=0 the next cycle, word_cnt=0; a new start begins writing at addr 0x0.
- start held high through LOAD plus load_valid=1 in the start cycle -> no write in the start cycle and no session restart; writes begin the cycle after entering LOAD.
